// File: rtl/lock_controller_pkg.sv
// Shared types for the door-lock datapath: PIN packet, controller state
// encoding and the BCD digit limit, plus small PIN helper functions.
package lock_controller_pkg;

  typedef struct packed {
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] digit4;
    logic       status;
  } pinPac_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    OPEN    = 3'd2,
    FAIL    = 3'd3,
    UPDATE  = 3'd4,
    LOCKOUT = 3'd5
  } lock_state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // True when every digit of the packet is a decimal digit.
  function automatic logic pin_is_bcd(input pinPac_t p);
    return (p.digit1 <= BCD_MAX) && (p.digit2 <= BCD_MAX) &&
           (p.digit3 <= BCD_MAX) && (p.digit4 <= BCD_MAX);
  endfunction

endpackage

// File: rtl/lock_controller_tick.sv
// tick_timer: loadable down-counter. After a load of value V, done pulses
// for one cycle V cycles later (i.e. on the (V+1)-th cycle after the load).
module tick_timer #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;
  logic         armed;

  // Count down from the loaded value; disarm once zero has been reported.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      armed <= 1'b0;
    end else if (load) begin
      count <= load_val;
      armed <= 1'b1;
    end else if (armed) begin
      if (count == '0) armed <= 1'b0;
      else             count <= count - 1'b1;
    end
  end

  assign done = armed && (count == '0);

endmodule

// File: rtl/lock_controller.sv
// lock_controller: top-level sequencer of the door lock. Compares entered
// PINs with the master PIN, drives the door, failure counter and lockout,
// and gates master PIN updates.
// Optional feature: define LOCK_LOCKOUT_EN to generate the LOCKOUT state;
// without it lockout is tied low and FAIL always returns to IDLE.
module lock_controller
  import lock_controller_pkg::*;
#(
  parameter int          MAX_ATTEMPTS  = 3,
  parameter int          UNLOCK_TICKS  = 50,
  parameter int          LOCKOUT_TICKS = 300,
  parameter int          UPDATE_TICKS  = 200,
  parameter logic [15:0] DEFAULT_PIN   = 16'h1234
) (
  input  logic                              clk,
  input  logic                              rst,
  input  pinPac_t                           pin_in,
  input  logic                              update_req,
  input  pinPac_t                           new_pin_in,
  output logic                              update_en,
  output logic                              door_open,
  output logic                              lockout,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0] fail_cnt,
  output logic [2:0]                        state_o,
  output pinPac_t                           master_pin_o
);

  localparam int FW    = $clog2(MAX_ATTEMPTS + 1);
  localparam int T_A   = (UNLOCK_TICKS > UPDATE_TICKS) ? UNLOCK_TICKS : UPDATE_TICKS;
  localparam int T_MAX = (T_A > LOCKOUT_TICKS) ? T_A : LOCKOUT_TICKS;
  localparam int TW    = $clog2(T_MAX);

  localparam logic [FW-1:0] FAIL_MAX   = FW'(MAX_ATTEMPTS);
  localparam logic [TW-1:0] UNLOCK_LD  = TW'(UNLOCK_TICKS - 1);
  localparam logic [TW-1:0] UPDATE_LD  = TW'(UPDATE_TICKS - 1);
  localparam logic [TW-1:0] LOCKOUT_LD = TW'(LOCKOUT_TICKS - 1);
  localparam pinPac_t       RESET_PIN  = pinPac_t'({DEFAULT_PIN, 1'b0});

  lock_state_t   state_q, state_d;
  logic          pin_prev, new_prev;
  logic          pin_evt, new_evt;
  logic [15:0]   entry_digits;
  logic          entry_ld;
  logic          upd_mode_q, upd_mode_d;
  logic [FW-1:0] fail_q, fail_d;
  pinPac_t       master_q, master_d;
  logic          match;
  logic          tmr_load, tmr_done;
  logic [TW-1:0] tmr_val;

  // Failure counter increment that holds at the attempt limit.
  function automatic logic [FW-1:0] sat_inc(input logic [FW-1:0] v);
    return (v >= FAIL_MAX) ? FAIL_MAX : v + 1'b1;
  endfunction

  assign pin_evt = pin_in.status & ~pin_prev;
  assign new_evt = new_pin_in.status & ~new_prev;
  assign match   = (entry_digits == {master_q.digit1, master_q.digit2,
                                     master_q.digit3, master_q.digit4});

  // State, counters, master PIN and edge detectors; edge registers come out
  // of reset high so a status already asserted is not taken as an event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pin_prev   <= 1'b1;
      new_prev   <= 1'b1;
      upd_mode_q <= 1'b0;
      fail_q     <= '0;
      master_q   <= RESET_PIN;
    end else begin
      state_q    <= state_d;
      pin_prev   <= pin_in.status;
      new_prev   <= new_pin_in.status;
      upd_mode_q <= upd_mode_d;
      fail_q     <= fail_d;
      master_q   <= master_d;
    end
  end

  // Entered PIN digits, captured on a PIN event in IDLE.
  always_ff @(posedge clk) begin
    if (entry_ld) entry_digits <= {pin_in.digit1, pin_in.digit2,
                                   pin_in.digit3, pin_in.digit4};
  end

  // Next-state logic, counter and master PIN updates.
  always_comb begin
    state_d    = state_q;
    upd_mode_d = upd_mode_q;
    fail_d     = fail_q;
    master_d   = master_q;
    entry_ld   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pin_evt) begin
          entry_ld   = 1'b1;
          upd_mode_d = update_req;
          state_d    = CHECK;
        end
      end
      CHECK: begin
        if (match) begin
          state_d = upd_mode_q ? UPDATE : OPEN;
          fail_d  = '0;
        end else begin
          state_d = FAIL;
        end
      end
      OPEN: begin
        if (tmr_done) state_d = IDLE;
      end
      FAIL: begin
        fail_d = sat_inc(fail_q);
`ifdef LOCK_LOCKOUT_EN
        state_d = (sat_inc(fail_q) == FAIL_MAX) ? LOCKOUT : IDLE;
`else
        state_d = IDLE;
`endif
      end
      UPDATE: begin
        // A valid new PIN takes priority over a simultaneous timeout.
        if (new_evt && pin_is_bcd(new_pin_in)) begin
          master_d = pinPac_t'({new_pin_in.digit1, new_pin_in.digit2,
                                new_pin_in.digit3, new_pin_in.digit4, 1'b1});
          state_d  = IDLE;
        end else if (tmr_done) begin
          state_d = IDLE;
        end
      end
`ifdef LOCK_LOCKOUT_EN
      LOCKOUT: begin
        if (tmr_done) begin
          state_d = IDLE;
          fail_d  = '0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Timer is reloaded whenever a timed state is entered.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (state_d != state_q) begin
      case (state_d)
        OPEN:    begin tmr_load = 1'b1; tmr_val = UNLOCK_LD;  end
        UPDATE:  begin tmr_load = 1'b1; tmr_val = UPDATE_LD;  end
        LOCKOUT: begin tmr_load = 1'b1; tmr_val = LOCKOUT_LD; end
        default: begin tmr_load = 1'b0; tmr_val = '0;         end
      endcase
    end
  end

  tick_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  assign door_open    = (state_q == OPEN);
  assign update_en    = (state_q == UPDATE);
  assign fail_cnt     = fail_q;
  assign state_o      = state_q;
  assign master_pin_o = master_q;
`ifdef LOCK_LOCKOUT_EN
  assign lockout = (state_q == LOCKOUT);
`else
  assign lockout = 1'b0;
`endif

endmodule

// File: tb/tb_lock_controller.sv
// Scoreboard bench for lock_controller: stimulus queues expected output
// snapshots tagged with a clock-cycle number; a monitor compares them.
module tb_lock_controller;
  import lock_controller_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  pinPac_t    pin_in;
  logic       update_req;
  pinPac_t    new_pin_in;
  logic       update_en, door_open, lockout;
  logic [1:0] fail_cnt;
  logic [2:0] state_o;
  pinPac_t    master_pin_o;

  lock_controller dut (
    .clk(clk), .rst(rst), .pin_in(pin_in), .update_req(update_req),
    .new_pin_in(new_pin_in), .update_en(update_en), .door_open(door_open),
    .lockout(lockout), .fail_cnt(fail_cnt), .state_o(state_o),
    .master_pin_o(master_pin_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       name;
    logic [24:0] val;  // {door, lockout, update_en, fail_cnt, state, master}
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   applied = 0;
  int   miscompares = 0;

  localparam logic [16:0] M0 = {16'h1234, 1'b0};
  localparam logic [16:0] M1 = {16'h5678, 1'b1};

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    logic [24:0] act;
    act = {door_open, lockout, update_en, fail_cnt, state_o, 17'(master_pin_o)};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      applied++;
      if (e.cyc != cyc || act !== e.val) begin
        miscompares++;
        $display("FAIL %s cyc=%0d got=%h expected=%h (door,lock,upd,fail,state,master)",
                 e.name, cyc, act, e.val);
      end
    end
  end

  task automatic push(input int c, input string n, input logic d, input logic l,
                      input logic u, input logic [1:0] f, input logic [2:0] s,
                      input logic [16:0] m);
    exp_t e;
    e.cyc  = c;
    e.name = n;
    e.val  = {d, l, u, f, s, m};
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step_to(input int t);
    while (cyc < t) step(1);
  endtask

  task automatic pin_pulse(input logic [15:0] d);
    pin_in = pinPac_t'({d, 1'b1});
    step(1);
    pin_in.status = 1'b0;
  endtask

  task automatic new_pulse(input logic [15:0] d);
    new_pin_in = pinPac_t'({d, 1'b1});
    step(1);
    new_pin_in.status = 1'b0;
  endtask

  initial begin
    int c;
    rst        = 1'b0;
    pin_in     = '0;
    new_pin_in = '0;
    update_req = 1'b0;
    step(3);
    applied++;
    if ({door_open, lockout, update_en} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_outputs got=%b", {door_open, lockout, update_en});
    end
    applied++;
    if (17'(master_pin_o) !== M0) begin
      miscompares++;
      $display("FAIL reset_master got=%h", 17'(master_pin_o));
    end
    push(cyc, "reset", 0, 0, 0, 2'd0, 3'd0, M0);
    step(1);
    rst = 1'b1;
    step(2);

    // Correct PIN opens the door for 50 cycles; PIN entry during OPEN ignored.
    c = cyc;
    push(c + 1,  "t1_check",      0, 0, 0, 2'd0, 3'd1, M0);
    push(c + 2,  "t1_open_first", 1, 0, 0, 2'd0, 3'd2, M0);
    push(c + 51, "t1_open_last",  1, 0, 0, 2'd0, 3'd2, M0);
    push(c + 52, "t1_idle",       0, 0, 0, 2'd0, 3'd0, M0);
    pin_pulse(16'h1234);
    step_to(c + 10);
    pin_pulse(16'h9999);
    step_to(c + 54);
    c = cyc;
    push(c + 2, "t1_new_ignored", 0, 0, 0, 2'd0, 3'd0, M0);
    new_pulse(16'h5678);
    step_to(c + 4);

    // Wrong PINs count up.
    for (int i = 0; i < 2; i++) begin
      c = cyc;
      push(c + 2, "t3_fail_state", 0, 0, 0, 2'(i), 3'd3, M0);
      push(c + 3, "t3_fail_cnt",   0, 0, 0, 2'(i + 1), 3'd0, M0);
      pin_pulse(16'h9999);
      step_to(c + 4);
    end
    c = cyc;
    push(c + 2, "t3_fail3_state", 0, 0, 0, 2'd2, 3'd3, M0);
`ifdef LOCK_LOCKOUT_EN
    push(c + 3,   "t2_lockout",   0, 1, 0, 2'd3, 3'd5, M0);
    push(c + 22,  "t2_ignored",   0, 1, 0, 2'd3, 3'd5, M0);
    push(c + 302, "t2_lock_last", 0, 1, 0, 2'd3, 3'd5, M0);
    push(c + 303, "t2_lock_done", 0, 0, 0, 2'd0, 3'd0, M0);
    pin_pulse(16'h9999);
    step_to(c + 20);
    pin_pulse(16'h1234);
    step_to(c + 305);
`else
    push(c + 3, "t3_fail3", 0, 0, 0, 2'd3, 3'd0, M0);
    pin_pulse(16'h9999);
    step_to(c + 4);
    c = cyc;
    push(c + 3, "t3_saturate", 0, 0, 0, 2'd3, 3'd0, M0);
    pin_pulse(16'h9999);
    step_to(c + 4);
    c = cyc;
    push(c + 1, "t3_check", 0, 0, 0, 2'd3, 3'd1, M0);
    push(c + 2, "t3_open",  1, 0, 0, 2'd0, 3'd2, M0);
    pin_pulse(16'h1234);
    step_to(c + 54);
`endif

    // Master PIN change to 5678.
    update_req = 1'b1;
    c = cyc;
    push(c + 1, "t4_check",  0, 0, 0, 2'd0, 3'd1, M0);
    push(c + 2, "t4_update", 0, 0, 1, 2'd0, 3'd4, M0);
    pin_pulse(16'h1234);
    update_req = 1'b0;
    step_to(c + 6);
    c = cyc;
    push(c,     "t4_pre_latch", 0, 0, 1, 2'd0, 3'd4, M0);
    push(c + 1, "t4_latched",   0, 0, 0, 2'd0, 3'd0, M1);
    new_pulse(16'h5678);
    step_to(c + 3);
    applied++;
    if (17'(master_pin_o) !== M1) begin
      miscompares++;
      $display("FAIL t4_master_direct got=%h", 17'(master_pin_o));
    end
    c = cyc;
    push(c + 3, "t4_old_fails", 0, 0, 0, 2'd1, 3'd0, M1);
    pin_pulse(16'h1234);
    step_to(c + 4);
    c = cyc;
    push(c + 1, "t4_check_new", 0, 0, 0, 2'd1, 3'd1, M1);
    push(c + 2, "t4_new_opens", 1, 0, 0, 2'd0, 3'd2, M1);
    pin_pulse(16'h5678);
    step_to(c + 54);

    // Non-BCD new PIN ignored; UPDATE times out after 200 cycles.
    update_req = 1'b1;
    c = cyc;
    push(c + 2,   "t5_update",      0, 0, 1, 2'd0, 3'd4, M1);
    push(c + 8,   "t5_bad_ignored", 0, 0, 1, 2'd0, 3'd4, M1);
    push(c + 201, "t5_last",        0, 0, 1, 2'd0, 3'd4, M1);
    push(c + 202, "t5_expired",     0, 0, 0, 2'd0, 3'd0, M1);
    pin_pulse(16'h5678);
    update_req = 1'b0;
    step_to(c + 5);
    new_pulse(16'h12A4);
    step_to(c + 204);

    // Asynchronous reset during OPEN.
    c = cyc;
    push(c + 2, "t6_open", 1, 0, 0, 2'd0, 3'd2, M1);
    pin_pulse(16'h5678);
    step_to(c + 10);
    #1;
    rst = 1'b0;
    push(cyc, "t6_rst_open", 0, 0, 0, 2'd0, 3'd0, M0);
    step(2);
    rst = 1'b1;
    step(2);

    // Change master, re-enter UPDATE, then reset with statuses held high.
    update_req = 1'b1;
    c = cyc;
    push(c + 2, "t6_update", 0, 0, 1, 2'd0, 3'd4, M0);
    pin_pulse(16'h1234);
    step_to(c + 4);
    c = cyc;
    push(c + 1, "t6_master_new", 0, 0, 0, 2'd0, 3'd0, M1);
    new_pulse(16'h5678);
    step_to(c + 3);
    c = cyc;
    push(c + 2, "t6_update2", 0, 0, 1, 2'd0, 3'd4, M1);
    pin_pulse(16'h5678);
    update_req = 1'b0;
    step_to(c + 6);
    #1;
    rst = 1'b0;
    push(cyc, "t6_rst_update", 0, 0, 0, 2'd0, 3'd0, M0);
    pin_in     = pinPac_t'({16'h1234, 1'b1});
    new_pin_in = pinPac_t'({16'h5678, 1'b1});
    step(2);
    rst = 1'b1;
    c = cyc;
    push(c + 1, "t6_no_evt1", 0, 0, 0, 2'd0, 3'd0, M0);
    push(c + 3, "t6_no_evt3", 0, 0, 0, 2'd0, 3'd0, M0);
    step_to(c + 5);
    applied++;
    if (state_o !== 3'd0) begin
      miscompares++;
      $display("FAIL t6_state_direct got=%0d", state_o);
    end
    applied++;
    if (fail_cnt !== 2'd0) begin
      miscompares++;
      $display("FAIL t6_fail_direct got=%0d", fail_cnt);
    end
    pin_in.status     = 1'b0;
    new_pin_in.status = 1'b0;

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 20 && sb.size() > 0; k++) step(1);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      applied++;
      miscompares++;
      $display("FAIL %s never checked: due cyc=%0d now cyc=%0d", e.name, e.cyc, cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
